// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for a 5-stage pipeline with memory-wait timeout and perf counters
// Ports: clk, rst_n (async, active-low); id_rs1/id_rs2/id_use_rs1/id_use_rs2 (ID sources);
//        ex_rd/ex_memread/ex_redirect (EX state); mem_req/dmem_ready (MEM handshake);
//        pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_bubble (pipeline control);
//        mem_timeout (sticky error); cnt_lu, cnt_mem, cnt_flush (saturating counters)
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int TMO_W = 8,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_memread,
  input  logic             ex_redirect,
  input  logic             mem_req,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_flush,
  output logic             ex_mem_en,
  output logic             mem_wb_bubble,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] cnt_lu,
  output logic [CNT_W-1:0] cnt_mem,
  output logic [CNT_W-1:0] cnt_flush
);
  typedef enum logic [1:0] {RUN, MEM_WAIT, TIMEOUT} state_t;
  state_t state;
  logic [TMO_W-1:0] wait_cnt;
  logic mem_stall, load_use, frozen, redir, lu_take;
  assign mem_stall = mem_req & ~dmem_ready;
  assign load_use = ex_memread & (ex_rd != 5'd0) &
                    ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
  // TIMEOUT freezes the pipeline exactly like a live memory stall
  assign frozen = (state == TIMEOUT) | mem_stall;
  assign redir = ~frozen & ex_redirect;
  assign lu_take = ~frozen & ~ex_redirect & load_use;
  // every control output is forced low while reset is held
  assign pc_en = rst_n & ~frozen & ~lu_take;
  assign if_id_en = rst_n & ~frozen & ~lu_take;
  assign if_id_flush = rst_n & redir;
  assign id_ex_en = rst_n & ~frozen;
  assign id_ex_flush = rst_n & (redir | lu_take);
  assign ex_mem_en = rst_n & ~frozen;
  assign mem_wb_bubble = rst_n & frozen;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      wait_cnt <= '0;
      mem_timeout <= 1'b0;
      cnt_lu <= '0;
      cnt_mem <= '0;
      cnt_flush <= '0;
    end else begin
      cnt_lu <= cnt_lu + CNT_W'(lu_take && !(&cnt_lu));
      cnt_mem <= cnt_mem + CNT_W'(frozen && !(&cnt_mem));
      cnt_flush <= cnt_flush + CNT_W'(redir && !(&cnt_flush));
      case (state)
        RUN: if (mem_stall) begin
          state <= MEM_WAIT;
          wait_cnt <= TMO_W'(1);
        end
        // a dropped mem_req is treated like ready
        MEM_WAIT: if (!mem_stall) begin
          state <= RUN;
          wait_cnt <= '0;
        end else if (wait_cnt == TMO_W'(MEM_TIMEOUT)) begin
          state <= TIMEOUT;
          mem_timeout <= 1'b1;
        end else begin
          wait_cnt <= wait_cnt + TMO_W'(1);
        end
        default: state <= TIMEOUT;
      endcase
    end
  end
endmodule
